alu_issue_ctrl: RTL

//  Driving side of the 3-bit-opcode ALU interface. Accepts one instruction word plus rs/rt register values per handshake.

---
 rtl/alu_issue_ctrl_pkg.sv | 33 +++
 rtl/alu_issue_ctrl_decode.sv | 81 ++++++++
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue slice: ALU opcodes, instruction op/funct codes and FSM states.
// Consumed by alu_decode and alu_issue_ctrl.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational decode of one instruction word plus rs/rt values into ALU operands and opcode.
// Unknown encodings fall back to an rs+rt ADD and raise illegal_o.
module alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] rsVal_i,
    input  logic [DATA_WIDTH-1:0] rtVal_i,
    output logic [DATA_WIDTH-1:0] in1_o,
    output logic [DATA_WIDTH-1:0] in2_o,
    output logic [2:0]            opcode_o,
    output logic                  isMul_o,
    output logic                  illegal_o
);

    logic [5:0]            op;
    logic [5:0]            funct;
    logic [4:0]            shamt;
    logic [15:0]           imm;
    logic [DATA_WIDTH-1:0] immSext;
    logic [DATA_WIDTH-1:0] immZext;
    logic [DATA_WIDTH-1:0] shamtZext;
    logic                  unusedRegFields;

    assign op        = instr_i[31:26];
    assign funct     = instr_i[5:0];
    assign shamt     = instr_i[10:6];
    assign imm       = instr_i[15:0];
    assign immSext   = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign immZext   = {{(DATA_WIDTH-16){1'b0}}, imm};
    assign shamtZext = {{(DATA_WIDTH-5){1'b0}}, shamt};
    // Register-number fields are resolved upstream; only their values arrive here.
    assign unusedRegFields = ^instr_i[25:16];

    always_comb begin
        in1_o     = rsVal_i;
        in2_o     = rtVal_i;
        opcode_o  = ALU_ADD;
        illegal_o = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FUNCT_AND: opcode_o = ALU_AND;
                    FUNCT_OR:  opcode_o = ALU_OR;
                    FUNCT_ADD: opcode_o = ALU_ADD;
                    FUNCT_SUB: opcode_o = ALU_SUB;
                    FUNCT_MUL: opcode_o = ALU_MUL;
                    FUNCT_SLL: begin
                        opcode_o = ALU_SLL;
                        in1_o    = rtVal_i;
                        in2_o    = shamtZext;
                    end
                    default:   illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: begin
                opcode_o = ALU_ADD;
                in2_o    = immSext;
            end
            OP_ANDI: begin
                opcode_o = ALU_AND;
                in2_o    = immZext;
            end
            OP_ORI: begin
                opcode_o = ALU_OR;
                in2_o    = immZext;
            end
            OP_BEQ:  opcode_o = ALU_SUB;
            OP_LW, OP_SW: begin
                opcode_o = ALU_ADD;
                in2_o    = immSext;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign isMul_o = (opcode_o == ALU_MUL);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving a 3-bit-opcode ALU: accept, hold operands through EXEC, present result on a valid/ready port.
// Optional feature macro ILLEGAL_TRAP_EN: illegal decodes bypass the ALU and report out_illegal.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_rs_val,
    input  logic [DATA_WIDTH-1:0] in_rt_val,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [2:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_illegal
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] aluIn1_q;
    logic [DATA_WIDTH-1:0] aluIn2_q;
    logic [2:0]            aluOpcode_q;
    logic [DATA_WIDTH-1:0] outResult_q;
    logic                  outZero_q;
    logic                  isMul_q;
    logic [CNT_W-1:0]      mulCnt_q;
    logic [CNT_W-1:0]      mulCnt_d;

    logic [DATA_WIDTH-1:0] decIn1;
    logic [DATA_WIDTH-1:0] decIn2;
    logic [2:0]            decOpcode;
    logic                  decIsMul;
    logic                  decIllegal;

    alu_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .instr_i   (in_instr),
        .rsVal_i   (in_rs_val),
        .rtVal_i   (in_rt_val),
        .in1_o     (decIn1),
        .in2_o     (decIn2),
        .opcode_o  (decOpcode),
        .isMul_o   (decIsMul),
        .illegal_o (decIllegal)
    );

    assign mulCnt_d = mulCnt_q + 1'b1;

`ifdef ILLEGAL_TRAP_EN
    logic outIllegal_q;
    assign out_illegal = outIllegal_q;
`else
    logic unusedIllegal;
    assign unusedIllegal = decIllegal;
    assign out_illegal   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            aluIn1_q    <= '0;
            aluIn2_q    <= '0;
            aluOpcode_q <= ALU_ADD;
            outResult_q <= '0;
            outZero_q   <= 1'b0;
            isMul_q     <= 1'b0;
            mulCnt_q    <= '0;
`ifdef ILLEGAL_TRAP_EN
            outIllegal_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifdef ILLEGAL_TRAP_EN
                        outIllegal_q <= decIllegal;
                        if (decIllegal) begin
                            outResult_q <= '0;
                            outZero_q   <= 1'b0;
                            state_q     <= DONE;
                        end else
`endif
                        begin
                            aluIn1_q    <= decIn1;
                            aluIn2_q    <= decIn2;
                            aluOpcode_q <= decOpcode;
                            isMul_q     <= decIsMul;
                            mulCnt_q    <= '0;
                            state_q     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Multiply holds the operands for MUL_LATENCY edges before its result is trusted.
                    if (!isMul_q || (mulCnt_q == MUL_LAST)) begin
                        outResult_q <= alu_result;
                        outZero_q   <= alu_zero;
                        mulCnt_q    <= '0;
                        state_q     <= DONE;
                    end else begin
                        mulCnt_q <= mulCnt_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign alu_in1    = aluIn1_q;
    assign alu_in2    = aluIn2_q;
    assign alu_opcode = aluOpcode_q;
    assign out_result = outResult_q;
    assign out_zero   = outZero_q;

endmodule
